uart_tx: RTL and testbench

- Serial UART transmitter. It is the transmit-side counterpart of the single-bit capture/receive logic in the CPU I/O path.
- Accepts one parallel byte via a valid/ready handshake and shifts it out on a single line: start bit, data bits LSB-first, optional parity, then stop.
- Sits between the CPU's memory-mapped I/O register and the board TX pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_baud_tick.sv | 27 ++
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and line levels, common to uart_tx and the future uart_rx.
package uart_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic       LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_START  = START,
        S_DATA   = DATA,
        S_PARITY = PARITY,
        S_STOP   = STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last cycle of each bit.
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// Parity stage is built only when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | line low for one bit period
// DATA   | shifting payload out LSB-first
// PARITY | even parity of latched byte (UART_TX_PARITY_EN only)
// STOP   | line high for one bit period
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_BITS + 1);

    uart_state_t          r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [BCW-1:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 w_tick;
    logic                 w_accept;

    assign w_accept = (r_state == S_IDLE) && tx_valid;
    assign tx_ready = (r_state == S_IDLE);
    assign busy     = ~tx_ready;
    assign tx       = r_tx;

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(w_accept),
        .tick (w_tick)
    );

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    // Parity is taken from the byte at accept, since the shift register is consumed by the time it is sent.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^tx_data;
        end
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tx_nxt      = r_tx;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = LINE_IDLE;
                if (tx_valid) begin
                    w_state_nxt   = S_START;
                    w_shift_nxt   = tx_data;
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == BCW'(DATA_BITS - 1)) begin
                        w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_nxt   = S_PARITY;
                        w_tx_nxt      = r_parity;
`else
                        w_state_nxt   = S_STOP;
                        w_tx_nxt      = LINE_IDLE;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = LINE_IDLE;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = LINE_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= LINE_IDLE;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus random traffic against a frame-queue model.
// Define UART_TX_PARITY_EN for both RTL and bench to exercise the parity build.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DB + 3;
`else
    localparam int NBITS = DB + 2;
`endif
    localparam int FRAME_LEN = NBITS * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic [DB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx;
    logic          busy;

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    bit   q_line[$];
    bit   m_ready = 1'b1;
    bit   exp_tx = 1'b1;
    int   m_accepts = 0;
    int   lo_run = 0;
    int   last_lo_run = 0;
    bit   rec_on = 1'b0;
    logic rec[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A frame is just the list of line levels, one entry per clock.
    function automatic void push_frame(input logic [DB-1:0] d);
        for (int c = 0; c < CPB; c++) q_line.push_back(1'b0);
        for (int i = 0; i < DB; i++)
            for (int c = 0; c < CPB; c++) q_line.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        for (int c = 0; c < CPB; c++) q_line.push_back(^d);
`endif
        for (int c = 0; c < CPB; c++) q_line.push_back(1'b1);
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) begin
            q_line.delete();
        end else if (m_ready && tx_valid) begin
            push_frame(tx_data);
            m_accepts++;
        end
        if (q_line.size() > 0) begin
            exp_tx  = q_line.pop_front();
            m_ready = 1'b0;
        end else begin
            exp_tx  = 1'b1;
            m_ready = 1'b1;
        end
        @(negedge clk);
        chk("tx", 32'(tx), 32'(exp_tx));
        chk("tx_ready", 32'(tx_ready), 32'(m_ready));
        chk("busy", 32'(busy), 32'(!m_ready));
        if (rec_on) rec.push_back(tx);
        if (tx_ready === 1'b0) begin
            lo_run++;
        end else begin
            if (lo_run > 0) last_lo_run = lo_run;
            lo_run = 0;
        end
    endtask

    task automatic send(input logic [DB-1:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        step();
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [9:0] a5_pat;
        int         start_acc;
        int         guard;

        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();

        // 0xA5 single frame with recorded waveform
        last_lo_run = 0;
        rec.delete();
        rec_on = 1'b1;
        send(8'hA5);
        repeat (FRAME_LEN + 2) step();
        rec_on = 1'b0;
        chk("a5_ready_low_len", 32'(last_lo_run), 32'(FRAME_LEN));
        a5_pat = 10'b1101001010;
        for (int b = 0; b < 9; b++) chk("a5_bit", 32'(rec[b * CPB + 1]), 32'(a5_pat[b]));
        chk("a5_stop", 32'(rec[FRAME_LEN - 1]), 32'd1);
`ifdef UART_TX_PARITY_EN
        chk("a5_parity", 32'(rec[9 * CPB + 2]), 32'd0);
        rec.delete();
        rec_on = 1'b1;
        send(8'h07);
        repeat (FRAME_LEN + 2) step();
        rec_on = 1'b0;
        chk("p07_parity", 32'(rec[9 * CPB + 2]), 32'd1);
        chk("p07_len", 32'(last_lo_run), 32'd44);
`endif

        // back-to-back with tx_valid held
        start_acc = m_accepts;
        tx_valid  = 1'b1;
        tx_data   = 8'h00;
        step();
        tx_data = 8'hFF;
        guard   = 0;
        while (m_accepts - start_acc < 2 && guard < 3 * FRAME_LEN) begin
            step();
            guard++;
        end
        tx_valid = 1'b0;
        chk("b2b_accepts", 32'(m_accepts - start_acc), 32'd2);
        repeat (FRAME_LEN + 2) step();

        // tx_valid pulse while busy is ignored
        send(8'hC3);
        repeat (10) step();
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        step();
        tx_valid = 1'b0;
        repeat (FRAME_LEN) step();

        // reset during data bit 3 of 0x55, then a clean 0x81
        send(8'h55);
        repeat (CPB * 4 + 2) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_ready", 32'(tx_ready), 32'd1);
        step();
        send(8'h81);
        repeat (FRAME_LEN + 2) step();

        // tx_data changes after accept have no effect
        send(8'h12);
        tx_data = 8'hEE;
        repeat (FRAME_LEN + 2) step();

        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = DB'($urandom);
            rst      = ($urandom_range(0, 499) != 0);
            step();
        end
        rst      = 1'b1;
        tx_valid = 1'b0;
        repeat (FRAME_LEN + 2) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
